// File: rtl/lfsr_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lfsr_pkg
//  Desc     : Shared LFSR constants and the period-checker state encoding.
//  Revision : 1.0
// ============================================================================
package lfsr_pkg;

  localparam int LFSR_WIDTH = 8;

  // Reference polynomial x^8+x^6+x^5+x^4+1 as a Fibonacci tap mask on bits 7,5,4,3
  localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_COUNT = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } chk_state_e;

endpackage : lfsr_pkg
`default_nettype wire

// File: rtl/lfsr_period_checker.sv
`default_nettype none
// ============================================================================
//  Module   : lfsr_period_checker
//  Desc     : Measures the recurrence period of a sampled LFSR stream and
//             flags all-zero lock-up or a missing recurrence (timeout).
//  Revision : 1.0
// ============================================================================
module lfsr_period_checker
  import lfsr_pkg::*;
#(
  parameter int WIDTH = LFSR_WIDTH,
  parameter int CNT_W = WIDTH + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] val_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] period_o,
  output logic             lockup_o,
  output logic             timeout_o
);

  localparam logic [CNT_W-1:0] c_limit = CNT_W'(1) << WIDTH;

  chk_state_e       state_q, state_d;
  logic [WIDTH-1:0] ref_q, ref_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             lockup_q, lockup_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] cnt_inc;

  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    state_d   = state_q;
    ref_d     = ref_q;
    cnt_d     = cnt_q;
    period_d  = period_q;
    lockup_d  = lockup_q;
    timeout_d = timeout_q;

    unique case (state_q)
      ST_IDLE, ST_ARM: begin
        if (!start_i) begin
          state_d = ST_IDLE;
        end else if (valid_i) begin
          // Capture: an all-zero first sample can never recur meaningfully
          if (val_i == '0) begin
            state_d  = ST_ERR;
            lockup_d = 1'b1;
          end else begin
            state_d = ST_COUNT;
            ref_d   = val_i;
            cnt_d   = '0;
          end
        end else begin
          state_d = ST_ARM;
        end
      end
      ST_COUNT: begin
        if (!start_i) begin
          state_d = ST_IDLE;
        end else if (valid_i) begin
          if (val_i == '0) begin
            state_d  = ST_ERR;
            lockup_d = 1'b1;
          end else if (val_i == ref_q) begin
            state_d  = ST_DONE;
            period_d = cnt_inc;
          end else if (cnt_inc == c_limit) begin
            state_d   = ST_ERR;
            timeout_d = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      ST_DONE, ST_ERR: begin
        if (!start_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Flags only survive while the FSM stays in the state that raised them
    if (state_d != ST_ERR) begin
      lockup_d  = 1'b0;
      timeout_d = 1'b0;
    end
    busy_d = (state_d == ST_ARM) || (state_d == ST_COUNT);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      ref_q     <= '0;
      cnt_q     <= '0;
      period_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      lockup_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ref_q     <= ref_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      lockup_q  <= lockup_d;
      timeout_q <= timeout_d;
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign period_o  = period_q;
  assign lockup_o  = lockup_q;
  assign timeout_o = timeout_q;

endmodule : lfsr_period_checker
`default_nettype wire

// File: tb/tb_lfsr_period_checker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lfsr_period_checker
//  Desc     : Scoreboard bench for lfsr_period_checker with a stream-level model.
//  Revision : 1.0
// ============================================================================
module tb_lfsr_period_checker;
  import lfsr_pkg::*;

  localparam int W  = 8;
  localparam int CW = 9;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          start_i = 1'b0;
  logic          valid_i = 1'b0;
  logic [W-1:0]  val_i = '0;
  logic          busy_o, done_o, lockup_o, timeout_o;
  logic [CW-1:0] period_o;

  lfsr_period_checker #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .valid_i(valid_i), .val_i(val_i),
    .busy_o(busy_o), .done_o(done_o), .period_o(period_o),
    .lockup_o(lockup_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int kind; int period; int cyc; } exp_t;  // kind: 1 done, 2 lockup, 3 timeout
  exp_t sb[$];
  logic [W-1:0] stim[$];

  int checks = 0;
  int failures = 0;
  int last_period = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every rising result flag
  logic pd = 1'b0, pl = 1'b0, pt = 1'b0;
  always @(negedge clk) begin
    if (!rst_i) begin
      if ((done_o && !pd) || (lockup_o && !pl) || (timeout_o && !pt)) begin
        int kind_a;
        exp_t e;
        kind_a = done_o ? 1 : (lockup_o ? 2 : 3);
        check("flags_exclusive", int'(done_o) + int'(lockup_o) + int'(timeout_o), 1);
        if (sb.size() == 0) begin
          check("unexpected_result_kind", kind_a, 0);
        end else begin
          e = sb.pop_front();
          check("result_kind", kind_a, e.kind);
          check("result_period", int'(period_o), e.period);
          check("result_cycle", cyc, e.cyc);
        end
      end
    end
    pd = done_o; pl = lockup_o; pt = timeout_o;
  end

  // Reference model: outcome of a whole stream, from the period definition
  task automatic model(output int dec, output int kind, output int per);
    dec = -1; kind = 0; per = 0;
    if (stim.size() == 0) return;
    if (stim[0] == '0) begin dec = 0; kind = 2; return; end
    for (int k = 1; k < stim.size(); k++) begin
      if (stim[k] == '0)           begin dec = k; kind = 2; return; end
      if (stim[k] == stim[0])      begin dec = k; kind = 1; per = k; return; end
      if (k == 256)                begin dec = k; kind = 3; return; end
    end
  endtask

  task automatic gen_lfsr(input logic [W-1:0] seed, input int n);
    logic [W-1:0] s;
    s = seed;
    stim.delete();
    for (int i = 0; i < n; i++) begin
      stim.push_back(s);
      s = {s[W-2:0], ^(s & LFSR_TAPS)};
    end
  endtask

  task automatic run_stream(input int n_drive, input int max_gap, input bit immediate);
    int dec, kind, per, gap;
    exp_t e;
    bit decided;
    model(dec, kind, per);
    decided = 1'b0;
    start_i = 1'b1;
    if (!immediate) begin @(posedge clk); #1; end
    for (int i = 0; i < n_drive && i < stim.size(); i++) begin
      valid_i = 1'b1;
      val_i   = stim[i];
      if (i == dec) begin
        e.kind   = kind;
        e.period = (kind == 1) ? per : last_period;
        e.cyc    = cyc + 1;
        sb.push_back(e);
        if (kind == 1) last_period = per;
        decided = 1'b1;
      end
      @(posedge clk); #1;
      valid_i = 1'b0;
      gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      repeat (gap) begin
        if (!decided) check("busy_in_gap", int'(busy_o), 1);
        @(posedge clk); #1;
      end
    end
    repeat (2) begin @(posedge clk); #1; end
    if (decided) begin
      check("sticky_done", int'(done_o), int'(kind == 1));
      check("sticky_lockup", int'(lockup_o), int'(kind == 2));
      check("sticky_timeout", int'(timeout_o), int'(kind == 3));
    end
  endtask

  task automatic end_run();
    start_i = 1'b0;
    @(posedge clk); #1;
    check("idle_busy", int'(busy_o), 0);
    check("idle_done", int'(done_o), 0);
    check("idle_lockup", int'(lockup_o), 0);
    check("idle_timeout", int'(timeout_o), 0);
    check("idle_period", int'(period_o), last_period);
    @(posedge clk); #1;
  endtask

  task automatic apply_reset(input string tag);
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    last_period = 0;
    check({tag, "_busy"}, int'(busy_o), 0);
    check({tag, "_done"}, int'(done_o), 0);
    check({tag, "_lockup"}, int'(lockup_o), 0);
    check({tag, "_timeout"}, int'(timeout_o), 0);
    check({tag, "_period"}, int'(period_o), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    apply_reset("reset");

    // Maximal LFSR from 0xAA, no gaps
    gen_lfsr(8'hAA, 260);
    run_stream(260, 0, 1'b0);
    end_run();

    // Short loop with 2-cycle gaps
    stim = '{8'h11, 8'h22, 8'h33, 8'h11};
    start_i = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      exp_t e;
      valid_i = 1'b1; val_i = stim[i];
      if (i == 3) begin
        e.kind = 1; e.period = 3; e.cyc = cyc + 1;
        sb.push_back(e);
        last_period = 3;
      end
      @(posedge clk); #1;
      valid_i = 1'b0;
      if (i < 3) repeat (2) begin check("gap_busy", int'(busy_o), 1); @(posedge clk); #1; end
    end
    check("gap_done", int'(done_o), 1);
    end_run();

    // Lock-up mid-stream and on capture
    stim = '{8'h11, 8'h05, 8'h00};
    run_stream(3, 1, 1'b1);
    end_run();
    stim = '{8'h00, 8'h42};
    run_stream(2, 0, 1'b0);
    end_run();

    // Timeout: no recurrence of the reference
    stim.delete();
    stim.push_back(8'h11);
    repeat (300) stim.push_back(8'h55);
    run_stream(301, 0, 1'b1);
    end_run();

    // Abort after 100 samples, then a clean rerun
    gen_lfsr(8'hAA, 260);
    run_stream(100, 0, 1'b0);
    end_run();
    run_stream(260, 0, 1'b0);
    end_run();

    // Reset during COUNT, then during DONE, with start held high
    gen_lfsr(8'h5C, 260);
    run_stream(50, 1, 1'b0);
    apply_reset("rst_count");
    run_stream(260, 0, 1'b0);
    apply_reset("rst_done");
    gen_lfsr(8'h01, 260);
    run_stream(260, 0, 1'b0);
    end_run();

    // Randomized streams
    for (int r = 0; r < 4; r++) begin
      gen_lfsr(8'($urandom_range(1, 255)), 258);
      run_stream(258, 2, 1'($urandom_range(0, 1)));
      end_run();
    end
    for (int r = 0; r < 8; r++) begin
      stim.delete();
      for (int i = 0; i < 20; i++) stim.push_back(8'($urandom_range(0, 4)));
      run_stream(20, 2, 1'($urandom_range(0, 1)));
      end_run();
    end
    for (int r = 0; r < 2; r++) begin
      logic [W-1:0] c;
      c = 8'($urandom_range(1, 255));
      stim = '{c, c, c};
      run_stream(3, 1, 1'b1);
      end_run();
    end

    check("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_lfsr_period_checker
`default_nettype wire
